// File: rtl/pipe_elastic.sv
// Elastic pipeline chain: STAGES payload slots with per-slot valid bits, valid/ready on both ends,
// combinational back-pressure, bubble collapse, per-slot kill and global flush.
module pipe_elastic #(
    parameter int N      = 32,
    parameter int STAGES = 4,
    parameter int CW     = $clog2(STAGES + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [N-1:0]      data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [N-1:0]      data_o,
    input  logic [STAGES-1:0] kill_mask_i,
    input  logic              flush_i,
    output logic [CW-1:0]     occupancy_o
);

    logic [STAGES-1:0] r_valid;
    logic [N-1:0]      r_data [STAGES];
    logic [CW-1:0]     r_occ;

    logic [STAGES-1:0] w_kill;
    logic [STAGES-1:0] w_live;
    logic [STAGES-1:0] w_rdy;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [CW-1:0]     w_kill_cnt;

    function automatic logic [CW-1:0] f_popcount(input logic [STAGES-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < STAGES; k++) begin
            cnt = cnt + CW'(v[k]);
        end
        return cnt;
    endfunction

    // A killed item counts as absent, so its slot is free to be overwritten this very cycle.
    always_comb begin
        w_kill = kill_mask_i | {STAGES{flush_i}};
        w_live = r_valid & ~w_kill;
        w_rdy  = '0;
        w_rdy[STAGES-1] = ~w_live[STAGES-1] | ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_rdy[k] = ~w_live[k] | w_rdy[k+1];
        end
        w_kill_cnt = f_popcount(r_valid & w_kill);
    end

    assign ready_o     = w_rdy[0];
    assign valid_o     = w_live[STAGES-1];
    assign data_o      = r_data[STAGES-1];
    assign occupancy_o = r_occ;
    assign w_in_fire   = valid_i & w_rdy[0];
    assign w_out_fire  = w_live[STAGES-1] & ready_i;

    // Data registers only load under a live incoming item; a held slot keeps its data even when killed.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid <= '0;
            r_occ   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_rdy[0]) begin
                r_valid[0] <= valid_i;
                if (valid_i) begin
                    r_data[0] <= data_i;
                end
            end else begin
                r_valid[0] <= w_live[0];
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_valid[k] <= w_live[k-1];
                    if (w_live[k-1]) begin
                        r_data[k] <= r_data[k-1];
                    end
                end else begin
                    r_valid[k] <= w_live[k];
                end
            end
            r_occ <= r_occ + CW'(w_in_fire) - CW'(w_out_fire) - w_kill_cnt;
        end
    end

    a_occ_consistent: assert property (@(posedge CLK) disable iff (!RST)
        (r_occ <= CW'(STAGES)) && (r_occ == f_popcount(r_valid)));

endmodule

// File: tb/tb_pipe_elastic.sv
// Bench for pipe_elastic: directed vector table, randomized run against a slot-array reference model,
// and an asynchronous reset check in the middle of a transfer.
module tb_pipe_elastic;

  localparam int N      = 32;
  localparam int STAGES = 4;
  localparam int CW     = $clog2(STAGES + 1);

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [N-1:0]      data_i = '0;
  logic [STAGES-1:0] kill_mask_i = '0;
  logic              ready_o;
  logic              valid_o;
  logic [N-1:0]      data_o;
  logic [CW-1:0]     occupancy_o;

  pipe_elastic #(.N(N), .STAGES(STAGES), .CW(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .kill_mask_i (kill_mask_i),
    .flush_i     (flush_i),
    .occupancy_o (occupancy_o)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // directed vectors: inputs for one cycle, outputs expected before that cycle's edge
  typedef struct {
    logic              vi;
    logic [N-1:0]      di;
    logic              ri;
    logic [STAGES-1:0] km;
    logic              fl;
    logic              e_rdy;
    logic              e_vld;
    logic [N-1:0]      e_dat;
    int                e_occ;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic vi, input logic [N-1:0] di, input logic ri,
                     input logic [STAGES-1:0] km, input logic fl,
                     input logic e_rdy, input logic e_vld, input logic [N-1:0] e_dat, input int e_occ);
    vec_t v;
    v.vi = vi; v.di = di; v.ri = ri; v.km = km; v.fl = fl;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat; v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  // scoreboard and reference model: items sit in an array of slots and slide forward into free space
  logic [N-1:0] exp_q[$];
  logic         m_v [STAGES];
  logic [N-1:0] m_d [STAGES];
  logic         n_v [STAGES];
  logic [N-1:0] n_d [STAGES];
  logic         live [STAGES];
  logic         e_rdy, e_vld;
  logic [N-1:0] e_dat;
  int           m_occ;

  task automatic model_cycle();
    m_occ = 0;
    for (int k = 0; k < STAGES; k++) begin
      m_occ += int'(m_v[k]);
      live[k] = m_v[k] && !(kill_mask_i[k] || flush_i);
      n_v[k] = 1'b0;
      n_d[k] = '0;
    end
    e_vld = live[STAGES-1];
    e_dat = m_d[STAGES-1];
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (live[k]) begin
        if (k == STAGES - 1) begin
          if (ready_i) exp_q.push_back(m_d[k]);
          else begin n_v[k] = 1'b1; n_d[k] = m_d[k]; end
        end else if (!n_v[k+1]) begin
          n_v[k+1] = 1'b1; n_d[k+1] = m_d[k];
        end else begin
          n_v[k] = 1'b1; n_d[k] = m_d[k];
        end
      end
    end
    e_rdy = !n_v[0];
    if (valid_i && e_rdy) begin
      n_v[0] = 1'b1;
      n_d[0] = data_i;
    end
    check("rnd_ready_o", N'(ready_o), N'(e_rdy));
    check("rnd_valid_o", N'(valid_o), N'(e_vld));
    check("rnd_occupancy", N'(occupancy_o), N'(m_occ));
    if (e_vld) check("rnd_data_o", data_o, e_dat);
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check("rnd_unexpected_out", data_o, 'x);
      end else begin
        check("rnd_out_order", data_o, exp_q.pop_front());
      end
    end
    for (int k = 0; k < STAGES; k++) begin
      m_v[k] = n_v[k];
      m_d[k] = n_d[k];
    end
  endtask

  task automatic drive(input logic vi, input logic [N-1:0] di, input logic ri,
                       input logic [STAGES-1:0] km, input logic fl);
    valid_i = vi; data_i = di; ready_i = ri; kill_mask_i = km; flush_i = fl;
  endtask

  initial begin
    // stream 0x11,0x22,0x33
    add(1, 'h11, 1, 4'b0000, 0,  1, 0, 'h0,  0);
    add(1, 'h22, 1, 4'b0000, 0,  1, 0, 'h0,  1);
    add(1, 'h33, 1, 4'b0000, 0,  1, 0, 'h0,  2);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  3);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h11, 3);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h22, 2);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h33, 1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  0);
    // back-pressure fill, then release and re-present 5,6
    add(1, 'h1,  0, 4'b0000, 0,  1, 0, 'h0,  0);
    add(1, 'h2,  0, 4'b0000, 0,  1, 0, 'h0,  1);
    add(1, 'h3,  0, 4'b0000, 0,  1, 0, 'h0,  2);
    add(1, 'h4,  0, 4'b0000, 0,  1, 0, 'h0,  3);
    add(1, 'h5,  0, 4'b0000, 0,  0, 1, 'h1,  4);
    add(1, 'h6,  0, 4'b0000, 0,  0, 1, 'h1,  4);
    add(1, 'h5,  1, 4'b0000, 0,  1, 1, 'h1,  4);
    add(1, 'h6,  1, 4'b0000, 0,  1, 1, 'h2,  4);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h3,  4);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h4,  3);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h5,  2);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h6,  1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  0);
    // bubble collapse under stall
    add(1, 'hA,  0, 4'b0000, 0,  1, 0, 'h0,  0);
    add(0, 'h0,  0, 4'b0000, 0,  1, 0, 'h0,  1);
    add(1, 'hB,  0, 4'b0000, 0,  1, 0, 'h0,  1);
    add(0, 'h0,  0, 4'b0000, 0,  1, 0, 'h0,  2);
    add(0, 'h0,  0, 4'b0000, 0,  1, 1, 'hA,  2);
    add(0, 'h0,  0, 4'b0000, 0,  1, 1, 'hA,  2);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'hA,  2);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'hB,  1);
    // selective kill of slots 0,1 on a full stalled chain
    add(1, 'h1,  0, 4'b0000, 0,  1, 0, 'h0,  0);
    add(1, 'h2,  0, 4'b0000, 0,  1, 0, 'h0,  1);
    add(1, 'h3,  0, 4'b0000, 0,  1, 0, 'h0,  2);
    add(1, 'h4,  0, 4'b0000, 0,  1, 0, 'h0,  3);
    add(0, 'h0,  0, 4'b0011, 0,  1, 1, 'h1,  4);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h1,  2);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h2,  1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  0);
    // global flush with a concurrent input
    add(1, 'h31, 0, 4'b0000, 0,  1, 0, 'h0,  0);
    add(1, 'h32, 0, 4'b0000, 0,  1, 0, 'h0,  1);
    add(1, 'h33, 0, 4'b0000, 0,  1, 0, 'h0,  2);
    add(1, 'h77, 0, 4'b0000, 1,  1, 0, 'h0,  3);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 1, 'h77, 1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  0);
    // kill beats out_fire on the output slot
    add(1, 'h41, 1, 4'b0000, 0,  1, 0, 'h0,  0);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  1);
    add(0, 'h0,  1, 4'b1000, 0,  1, 0, 'h0,  1);
    add(0, 'h0,  1, 4'b0000, 0,  1, 0, 'h0,  0);

    // reset: valid_i is ignored while RST is low
    drive(1, 'hDEAD, 1, '0, 0);
    repeat (2) @(negedge CLK);
    #1;
    check("rst_valid_o", N'(valid_o), '0);
    check("rst_data_o", data_o, '0);
    check("rst_ready_o", N'(ready_o), N'(1));
    check("rst_occupancy", N'(occupancy_o), '0);
    @(negedge CLK);
    RST = 1'b1;
    drive(0, '0, 0, '0, 0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i].vi, vecs[i].di, vecs[i].ri, vecs[i].km, vecs[i].fl);
      #1;
      check($sformatf("vec%0d_ready_o", i), N'(ready_o), N'(vecs[i].e_rdy));
      check($sformatf("vec%0d_valid_o", i), N'(valid_o), N'(vecs[i].e_vld));
      check($sformatf("vec%0d_occupancy", i), N'(occupancy_o), N'(vecs[i].e_occ));
      if (vecs[i].e_vld) check($sformatf("vec%0d_data_o", i), data_o, vecs[i].e_dat);
    end

    // randomized run; the directed table leaves the chain empty
    for (int k = 0; k < STAGES; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      drive(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 7) == 0) ? STAGES'($urandom) : '0, ($urandom_range(0, 31) == 0));
      #1;
      model_cycle();
    end
    check("sb_drained", N'(exp_q.size()), '0);

    // asynchronous reset between edges with three items in flight
    @(negedge CLK);
    drive(0, '0, 1, '0, 1);
    @(negedge CLK);
    drive(1, 'hC1, 0, '0, 0);
    @(negedge CLK);
    drive(1, 'hC2, 0, '0, 0);
    @(negedge CLK);
    drive(1, 'hC3, 0, '0, 0);
    @(negedge CLK);
    drive(0, '0, 0, '0, 0);
    @(negedge CLK);
    #1;
    check("pre_arst_occupancy", N'(occupancy_o), N'(3));
    check("pre_arst_valid_o", N'(valid_o), N'(1));
    check("pre_arst_data_o", data_o, 'hC1);
    #1;
    RST = 1'b0;
    #1;
    check("arst_valid_o", N'(valid_o), '0);
    check("arst_occupancy", N'(occupancy_o), '0);
    check("arst_data_o", data_o, '0);
    check("arst_ready_o", N'(ready_o), N'(1));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_elastic.md
Name: pipe_elastic

Overview:
- Parametrised elastic pipeline stage chain, successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers of the 5-stage core.
- Carries an N-bit payload through STAGES register slots with a per-slot valid bit.
- Uses a valid/ready handshake on both ends and backward back-pressure.
- Collapses bubbles and supports per-stage selective flush (branch kill of the younger stages) plus a global flush.

Parameters:
- N, 32, payload width in bits.
- STAGES, 4, number of register slots (≥1); slot 0 is nearest the input, slot STAGES-1 drives the output.
- CW, $clog2(STAGES+1), width of the occupancy count.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-low reset.
- valid_i  in  1  upstream payload valid.
- ready_o  out  1  chain can accept data_i this cycle.
- data_i  in  N  upstream payload.
- valid_o  out  1  slot STAGES-1 holds a live item.
- ready_i  in  1  downstream accepts data_o.
- data_o  out  N  payload of slot STAGES-1.
- kill_mask_i  in  STAGES  bit k kills the item in slot k this cycle.
- flush_i  in  1  kill all slots; equivalent to kill_mask_i all ones.
- occupancy_o  out  CW  registered count of live items.

Behaviour:
- Reset (RST=0, asynchronous): all slot valid bits = 0, slot data = 0, occupancy_o = 0. Consequently valid_o = 0, data_o = 0 and ready_o = 1 while in reset (provided valid_i is irrelevant; no capture happens).
- Kill vector: K[k] = kill_mask_i[k] | flush_i.
- Live item: live[k] = valid[k] & ~K[k]. A killed item is treated as absent for every decision in the same cycle.
- Output handshake: valid_o = live[STAGES-1]; data_o = data[STAGES-1], driven combinationally from the register. out_fire = valid_o & ready_i.
- Backward readiness, computed combinationally:
  - rdy[STAGES-1] = ~live[STAGES-1] | ready_i.
  - rdy[k] = ~live[k] | rdy[k+1].
  - ready_o = rdy[0].
  - in_fire = valid_i & ready_o.
- Slot update at the clock edge:
  - Slot k>0: if rdy[k], then valid[k] <= live[k-1] and data[k] <= data[k-1]; otherwise it holds.
  - Slot 0: if rdy[0], then valid[0] <= valid_i and data[0] <= data_i; otherwise it holds.
  - A slot that holds but was killed clears its valid bit; its data is don't-care, and the implementation keeps the old value.
  - Data registers load only when the incoming valid is 1, to avoid toggling.
- Bubble collapse: an item advances into any empty or killed slot even while downstream is stalled (ready_i=0).
- Latency: on an empty chain with ready_i=1, an item accepted at edge t is presented on valid_o after edge t+STAGES-1. Sustained throughput is 1 item per cycle.
- The upstream input is never killed: an item accepted in a cycle with flush_i=1 is still captured into slot 0. The kill applies to older items only, which matches a branch-redirect flush of in-flight instructions.
- Simultaneous out_fire and kill on slot STAGES-1: the kill wins. live=0, so valid_o=0 and there is no out_fire.
- Occupancy: occupancy_o <= occupancy_o + in_fire − out_fire − popcount(valid & K).
  - It always equals popcount(valid) after the edge.
  - It never exceeds STAGES.
  - Wrap-around is impossible by construction; an assertion checks this.
- Full chain: all live and ready_i=0 → ready_o=0, every slot holds, and occupancy stays at STAGES.
- Reset asserted mid-transfer: all state clears immediately. Items in flight are discarded and are not reported.

Test Plan:
- Reset then stream: RST low→high, ready_i=1, send 0x11,0x22,0x33 on consecutive cycles (STAGES=4) → valid_o first high 3 cycles after the first accept edge; data_o shows 0x11,0x22,0x33 back-to-back; occupancy_o peaks at 3 and returns to 0.
- Back-pressure fill: ready_i=0, valid_i=1 for 6 cycles with data 1..6 → ready_o drops after 4 accepts; occupancy_o=4; data_o=1. Then raise ready_i → output order 1,2,3,4, then 5,6 after re-accept, with no loss or duplication.
- Bubble collapse: load 0xA into a stalled chain so it sits in slot 3; insert 0xB two cycles later → 0xB advances to slot 2 while ready_i=0; occupancy_o=2.
- Selective kill: with a full stalled chain holding 1,2,3,4 (slot3=1), pulse kill_mask_i=4'b0011 for one cycle, then ready_i=1 → outputs are 1,2 only; occupancy_o goes 4→2; ready_o=1 in the kill cycle.
- Global flush with concurrent input: chain holds 3 items, flush_i=1 with valid_i=1, data_i=0x77 → next cycle occupancy_o=1 and the only item out is 0x77; valid_o=0 during the flush cycle.
- Async reset mid-stream: drop RST between clock edges with occupancy_o=3 → valid_o=0, occupancy_o=0, data_o=0 immediately, without waiting for a clock edge.
